// File: rtl/burst_memory_if.sv
// burst_memory_if: request/response bundle between a pipeline stage and its
// burst memory responder.
//   enable/rw/address/access_size/data_in : request, driven by the stage
//   data_out/data_valid/busy/error        : response, driven by the memory
interface burst_memory_if;
   logic        enable;
   logic        rw;
   logic [31:0] address;
   logic [1:0]  access_size;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        error;

   modport master (
      output enable, rw, address, access_size, data_in,
      input  data_out, data_valid, busy, error
   );

   modport slave (
      input  enable, rw, address, access_size, data_in,
      output data_out, data_valid, busy, error
   );
endinterface

// File: rtl/burst_memory.sv
// burst_memory: word-organised memory responder executing 1/4/8/16-word
// bursts, one beat per cycle, with a 1-cycle registered read path.
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any burst in progress
//   bus   : burst_memory_if.slave (request in, data/valid/busy/error out)
module burst_memory #(
   parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
   parameter int          DEPTH_WORDS = 65536
) (
   input  logic          clock,
   input  logic          reset,
   burst_memory_if.slave bus
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic {IDLE, BURST} state_e;

   state_e      state_q, state_d;
   logic        rw_q, rw_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  cnt_q, cnt_d;        // beats still to run after the current one
   logic [31:0] data_out_q;
   logic        data_valid_q;
   logic        error_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic        beat_go;
   logic        beat_rw;
   logic [31:0] beat_addr;
   logic        reject;
   logic [3:0]  len_m1;
   logic [31:0] offset;
   logic [31:0] word_off;
   logic        in_range;
   logic [AW-1:0] idx;

   always_comb begin
      unique case (bus.access_size)
         2'b00:   len_m1 = 4'd0;
         2'b01:   len_m1 = 4'd3;
         2'b10:   len_m1 = 4'd7;
         default: len_m1 = 4'd15;
      endcase
   end

   // Beat address decoding; subtraction wraps, so the explicit lower-bound
   // compare catches addresses below the base.
   assign offset   = beat_addr - BASE_ADDR;
   assign word_off = offset >> 2;
   assign in_range = (beat_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
   assign idx      = word_off[AW-1:0];

   always_comb begin
      state_d   = state_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      beat_go   = 1'b0;
      beat_rw   = rw_q;
      beat_addr = addr_q;
      reject    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.enable) begin
               if (bus.address[1:0] != 2'b00) begin
                  reject = 1'b1;
               end else begin
                  // Beat 0 executes at the accepting edge itself.
                  beat_go   = 1'b1;
                  beat_rw   = bus.rw;
                  beat_addr = bus.address;
                  if (len_m1 != 4'd0) begin
                     state_d = BURST;
                     rw_d    = bus.rw;
                     addr_d  = bus.address + 32'd4;
                     cnt_d   = len_m1;
                  end
               end
            end
         end
         BURST: begin
            beat_go = 1'b1;
            addr_d  = addr_q + 32'd4;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         data_valid_q <= beat_go & beat_rw;
         error_q      <= reject | (beat_go & ~in_range);
         if (beat_go && beat_rw) data_out_q <= in_range ? mem[idx] : 32'd0;
      end
   end

   // Storage is never cleared; reset only suppresses the write at its edge.
   always_ff @(posedge clock) begin
      if (!reset && beat_go && !beat_rw && in_range) mem[idx] <= bus.data_in;
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = (state_q == BURST);
   assign bus.error      = error_q;
endmodule

// File: tb/tb_burst_memory.sv
module tb_burst_memory;
   localparam logic [31:0] BASE = 32'h8002_0000;
   localparam int          DEPTH = 65536;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   logic [31:0] model [logic [31:0]];

   burst_memory_if bus();

   burst_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard: every read beat is popped and compared as it appears.
   always @(negedge clk) begin
      if (bus.data_valid === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected_beat: data_out=%h valid=1, required no beat", bus.data_out);
         end else begin
            exp_t x;
            x = sb.pop_front();
            if (bus.data_out !== x.d || bus.error !== x.e) begin
               miscompares++;
               $display("FAIL sb_beat: data_out=%h error=%b, required %h/%b",
                        bus.data_out, bus.error, x.d, x.e);
            end
         end
      end
   end

   // One clock edge per call; inputs change 1 time unit after the edge.
   task automatic drive(input logic en, input logic r, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] d);
      bus.enable = en; bus.rw = r; bus.address = a; bus.access_size = sz; bus.data_in = d;
      @(posedge clk); #1;
   endtask

   task automatic push_read(input logic [31:0] a);
      exp_t x;
      x.d = model[a]; x.e = 1'b0;
      sb.push_back(x);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b1, 1'b1, BASE, 2'b00, 32'd0);
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
      vectors++;
      if (bus.data_out !== 32'd0 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: out=%h v=%b b=%b e=%b, required all 0",
                  bus.data_out, bus.data_valid, bus.busy, bus.error);
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      drive(1'b1, 1'b0, BASE, 2'b00, 32'hDEAD_BEEF);
      model[BASE] = 32'hDEAD_BEEF;
      vectors++;
      if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_write: busy=%b valid=%b, required 0/0", bus.busy, bus.data_valid);
      end
      push_read(BASE);
      drive(1'b1, 1'b1, BASE, 2'b00, 32'd0);
      vectors++;
      if (bus.data_valid !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_read: valid=%b busy=%b, required 1/0", bus.data_valid, bus.busy);
      end
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, BASE + 32'(4*k), 2'b00, 32'(k));
         model[BASE + 32'(4*k)] = 32'(k);
      end
      for (int k = 0; k < 8; k++) begin
         push_read(BASE + 32'(4*k));
         drive(1'b1, 1'b1, BASE + 32'(4*k), 2'b00, 32'd0);
         vectors++;
         if (bus.data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_valid[%0d]: valid=%b, required 1", k, bus.data_valid);
         end
      end
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
   endtask

   task automatic test_burst4;
      logic [31:0] a;
      a = BASE + 32'h10;
      // Write 1..4; the extra requests during busy must be ignored.
      for (int k = 0; k < 4; k++) begin
         if (k == 0) drive(1'b1, 1'b0, a, 2'b01, 32'd1);
         else        drive(1'b1, 1'b1, BASE, 2'b00, 32'(k + 1));
         model[a + 32'(4*k)] = 32'(k + 1);
         vectors++;
         if (bus.busy !== (k < 3)) begin
            miscompares++;
            $display("FAIL burst4_wr_busy[%0d]: busy=%b, required %b", k, bus.busy, k < 3);
         end
      end
      // Read back immediately, write requests during busy must not land.
      for (int k = 0; k < 4; k++) push_read(a + 32'(4*k));
      for (int k = 0; k < 4; k++) begin
         if (k == 0) drive(1'b1, 1'b1, a, 2'b01, 32'd0);
         else        drive(1'b1, 1'b0, BASE, 2'b00, 32'hBAD0_BAD0);
         vectors++;
         if (bus.busy !== (k < 3)) begin
            miscompares++;
            $display("FAIL burst4_rd_busy[%0d]: busy=%b, required %b", k, bus.busy, k < 3);
         end
      end
      // Accepted at the edge after busy falls.
      push_read(a);
      drive(1'b1, 1'b1, a, 2'b00, 32'd0);
      push_read(BASE);
      drive(1'b1, 1'b1, BASE, 2'b00, 32'd0);
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
   endtask

   task automatic test_range;
      exp_t x;
      logic [31:0] a;
      drive(1'b1, 1'b1, BASE + 32'd2, 2'b00, 32'd0);
      vectors++;
      if (bus.error !== 1'b1 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL misaligned: error=%b valid=%b busy=%b, required 1/0/0",
                  bus.error, bus.data_valid, bus.busy);
      end
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
      vectors++;
      if (bus.error !== 1'b0) begin
         miscompares++;
         $display("FAIL error_pulse: error=%b, required 0", bus.error);
      end
      x.d = 32'd0; x.e = 1'b1;
      sb.push_back(x);
      drive(1'b1, 1'b1, 32'h8001_FFFC, 2'b00, 32'd0);
      drive(1'b1, 1'b0, 32'h8001_FFFC, 2'b00, 32'h5555_5555);
      vectors++;
      if (bus.error !== 1'b1 || bus.data_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL oor_write: error=%b valid=%b, required 1/0", bus.error, bus.data_valid);
      end
      a = BASE + 32'((DEPTH - 2) * 4);
      drive(1'b1, 1'b0, a, 2'b00, 32'hA5A5_0001);
      drive(1'b1, 1'b0, a + 32'd4, 2'b00, 32'hA5A5_0002);
      model[a] = 32'hA5A5_0001;
      model[a + 32'd4] = 32'hA5A5_0002;
      for (int k = 0; k < 16; k++) begin
         if (k < 2) begin
            push_read(a + 32'(4*k));
         end else begin
            x.d = 32'd0; x.e = 1'b1;
            sb.push_back(x);
         end
      end
      drive(1'b1, 1'b1, a, 2'b11, 32'd0);
      for (int k = 1; k < 16; k++) drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL burst16_end_busy: busy=%b, required 0", bus.busy);
      end
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
   endtask

   task automatic test_reset_mid;
      logic [31:0] a;
      a = BASE + 32'h100;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, a + 32'(4*k), 2'b00, 32'h100 + 32'(k));
         model[a + 32'(4*k)] = 32'h100 + 32'(k);
      end
      for (int k = 0; k < 3; k++) begin
         if (k == 0) drive(1'b1, 1'b0, a, 2'b10, 32'h200);
         else        drive(1'b0, 1'b1, BASE, 2'b00, 32'h200 + 32'(k));
         model[a + 32'(4*k)] = 32'h200 + 32'(k);
      end
      rst = 1'b1;
      drive(1'b1, 1'b1, BASE, 2'b00, 32'h203);
      vectors++;
      if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 32'd0 || bus.error !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: busy=%b valid=%b out=%h err=%b, required 0/0/0/0",
                  bus.busy, bus.data_valid, bus.data_out, bus.error);
      end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         push_read(a + 32'(4*k));
         drive(1'b1, 1'b1, a + 32'(4*k), 2'b00, 32'd0);
         vectors++;
         if (bus.data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_valid[%0d]: valid=%b, required 1", k, bus.data_valid);
         end
      end
      drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
   endtask

   initial begin
      bus.enable = 1'b0; bus.rw = 1'b0; bus.address = '0; bus.access_size = '0; bus.data_in = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_burst4();
      test_range();
      test_reset_mid();
      repeat (3) drive(1'b0, 1'b0, BASE, 2'b00, 32'd0);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d beats outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/burst_memory.md
# burst_memory

Word-organised instruction/data memory responder on the far end of the fetch-stage memory port. It accepts the address/rw/access_size/enable request a pipeline stage drives, and returns read data or commits write data. Bursts of 1, 4, 8 or 16 words run on consecutive cycles under an internal beat counter. It sits below fetch (instruction port) and memory stage (data port), one instance per port.

## Interface
- BASE_ADDR, 32'h80020000, byte address of word 0
- DEPTH_WORDS, 65536, number of 32-bit words stored
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- enable  input  1  request valid; sampled only when busy=0
- rw  input  1  1 = read, 0 = write
- address  input  32  byte address of first beat
- access_size  input  2  burst length: 00 = 1, 01 = 4, 10 = 8, 11 = 16 words
- data_in  input  32  write data, one word per beat
- data_out  output  32  read data, registered
- data_valid  output  1  data_out holds a read beat this cycle
- busy  output  1  burst in progress; new requests ignored
- error  output  1  one-cycle pulse per rejected or out-of-range beat

## Operation
- States: IDLE, BURST. Reset → IDLE. All outputs 0 at reset. Memory contents are not cleared.
- Accept: at a rising edge with reset=0, busy=0, enable=1. The block latches rw, burst length L, beat address A, and beat counter = L-1.
- Misaligned request (address[1:0] != 0): rejected. error=1 for one cycle, no beats, state stays IDLE.
- Word index = (beat address − BASE_ADDR) >> 2. A beat is out of range when address < BASE_ADDR or index ≥ DEPTH_WORDS.
- Arithmetic: subtraction and increment are 32-bit unsigned and wrap modulo 2^32. Index compare uses the full 32-bit difference.
- Read beat: data_out ← mem[index], data_valid ← 1.
  - Out of range: data_out ← 0, data_valid ← 1, error ← 1.
- Write beat: mem[index] ← data_in sampled at that beat's edge. data_valid ← 0.
  - Out of range: write dropped, error ← 1.
- Beat k (0..L-1) is executed at edge E0+k and uses address A+4k. Bursts do not wrap inside a block.
- L=1: state stays IDLE. Otherwise go to BURST after E0 and return to IDLE after the edge executing beat L-1.
- While in BURST, enable, rw, address and access_size are ignored. data_in is still consumed on write beats.
- Cycles with no beat: data_valid=0, error=0. data_out holds its last value.

## Timing
- Read latency: 1 cycle. Request sampled at E0 gives beat 0 on data_out after E0, and beat k after E0+k.
- Write: beat k data must be stable at edge E0+k.
- busy=1 after edges E0..E(L−2); busy=0 after E(L−1). The next request is accepted at E(L), so there is no dead cycle between bursts.
- L=1 requests can be accepted every cycle, giving one read per cycle. This matches fetch issuing a new PC each cycle.
- enable=0 (fetch stalled) produces no beat. The previous data_out is held and data_valid=0.
- Reset asserted at any edge aborts a burst in progress.
  - After that edge: busy=0, data_valid=0, data_out=0, error=0, state IDLE.
  - A pending write beat at that edge is not performed. Reset wins over a simultaneous enable.

## Test plan
- Single-word read/write: write 32'hDEADBEEF at 32'h80020000 (L=1), then read the same address. data_out=32'hDEADBEEF, data_valid=1 one cycle after the read request, busy stays 0.
- Back-to-back fetch: 8 consecutive L=1 reads from 32'h80020000 step 4, preloaded 0..7. data_out is 0..7 on 8 consecutive cycles, data_valid is continuously 1.
- 4-word burst:
  - Write 1,2,3,4 at 32'h80020010 (access_size=01). busy=1 for 3 cycles.
  - Read back with access_size=01. Beats are 1,2,3,4 on consecutive cycles.
  - A request presented while busy=1 is ignored. A request at the edge after busy falls is accepted.
- Range and alignment:
  - Read at 32'h80020002: error pulse, no data_valid.
  - Read at 32'h8001FFFC: data_out=0, data_valid=1, error=1.
  - 16-word burst starting at the last 2 valid words: beats 0–1 return data, beats 2–15 return 0 with error=1 each.
- Reset mid-burst: reset asserted during beat 3 of an 8-word write. The next edge gives busy=0 and data_valid=0. Words 0–2 are written, words 3–7 keep their old values, and a new L=1 read is accepted the cycle after reset deasserts.
